// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB requester-side controller.
//
// Contents:
//   apb_state_t  - APB protocol phase (IDLE, SETUP, ACCESS)
//   clog2_min1   - ceiling log2 clamped to at least 1, for sizing counters
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    // A count range of 0 or 1 values still needs a 1-bit register.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-winner pointer.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   req        request vector, one bit per requester
//   grant_en   pointer may advance this cycle (grant is actually taken)
//   grant      one-hot grant (zero when nothing is requested)
//   grant_idx  binary index of the granted requester
//
// Priority starts just after the previous winner. The pointer resets to
// NUM_REQ-1, which makes requester 0 the first to be served.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       grant_en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;
    logic             found;

    // Two passes: indices above the pointer first, then wrap around to the
    // indices at or below it. Constant loop indices keep selects static.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) > ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) <= ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (grant_en && found) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB3 requester-side controller sharing one bus among NUM_REQ requesters.
//
// Ports:
//   PCLK, PRESETn      clock, asynchronous active-low reset
//   req_valid/ready    per-requester command handshake (ready only in IDLE)
//   req_write/addr/wdata  packed per-requester command fields
//   rsp_valid          one-cycle completion pulse to the owning requester
//   rsp_rdata/rsp_err  response payload, qualified by any rsp_valid bit
//   PADDR..PWDATA      registered APB request outputs
//   PRDATA/PREADY/PSLVERR  APB completer inputs
//
// Each transfer runs IDLE -> SETUP -> ACCESS -> IDLE. A watchdog ends an
// ACCESS phase that has seen TIMEOUT_CYCLES cycles of PREADY=0 and reports
// it as an error; TIMEOUT_CYCLES=0 turns the watchdog off.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);
    // Counter value seen during the last permitted wait cycle.
    localparam logic [CNT_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb_state_t        state;
    logic [IDX_W-1:0]  owner;
    logic [CNT_W-1:0]  wait_cnt;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              idle;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign idle      = (state == IDLE);
    assign req_ready = idle ? grant : '0;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .req      (req_valid),
        .grant_en (idle),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    // Mux out the winning requester's command fields.
    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = req_write[i];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Protocol FSM. The APB address/data registers double as the latched
    // command, so they stay stable through SETUP and ACCESS by construction.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            owner     <= '0;
            wait_cnt  <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner    <= grant_idx;
                        PADDR    <= sel_addr;
                        PWRITE   <= sel_write;
                        PWDATA   <= sel_write ? sel_wdata : '0;
                        PSEL     <= 1'b1;
                        PENABLE  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL             <= 1'b0;
                        PENABLE          <= 1'b0;
                        state            <= IDLE;
                        rsp_valid[owner] <= 1'b1;
                        rsp_err          <= PSLVERR;
                        rsp_rdata        <= PWRITE ? '0 : PRDATA;
                    end else if ((TIMEOUT_CYCLES > 0) && (wait_cnt == WAIT_LAST)) begin
                        PSEL             <= 1'b0;
                        PENABLE          <= 1'b0;
                        state            <= IDLE;
                        rsp_valid[owner] <= 1'b1;
                        rsp_err          <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
